tiny_shader_sequencer: RTL and testbench

TINY_SHADER_SEQUENCER -- requirements
Module: tiny_shader_sequencer

---
 rtl/tiny_shader_pkg.sv | 13 +
 rtl/tiny_shader_sequencer.sv | 127 ++++++++++++
 tb/tb_tiny_shader_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_shader_pkg.sv
// Shared types and default sizing for the tiny shader instruction sequencer.
package tiny_shader_pkg;

    localparam int NUM_INSTR_DEF = 16;
    localparam int INSTR_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tiny_shader_sequencer.sv
// Streams one pixel program from a single-port RAM to the executor and arbitrates SPI program writes.
// Optional macro TINY_SHADER_OVERRUN_CNT_EN enables the saturating per-frame overrun counter.
module tiny_shader_sequencer
    import tiny_shader_pkg::*;
#(
    parameter int NUM_INSTR = NUM_INSTR_DEF,
    parameter int INSTR_W   = INSTR_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         pause_execute_i,
    input  logic                         pixel_start_i,
    input  logic                         next_frame_i,
    input  logic                         wr_req_i,
    input  logic [$clog2(NUM_INSTR)-1:0] wr_addr_i,
    input  logic [INSTR_W-1:0]           wr_data_i,
    output logic                         wr_ack_o,
    output logic [$clog2(NUM_INSTR)-1:0] mem_addr_o,
    output logic                         mem_we_o,
    output logic [INSTR_W-1:0]           mem_wdata_o,
    input  logic [INSTR_W-1:0]           mem_rdata_i,
    output logic [INSTR_W-1:0]           instr_o,
    output logic [$clog2(NUM_INSTR)-1:0] instr_idx_o,
    output logic                         instr_valid_o,
    output logic                         exec_done_o,
    output logic                         overrun_o,
    output logic [7:0]                   overrun_cnt_o,
    output logic [1:0]                   state_o
);

    localparam int AW = $clog2(NUM_INSTR);

    // Handshake: wr_req_i is held by the SPI side until wr_ack_o; the ack is
    // combinational and the write lands in RAM on the same rising edge.
    seq_state_t      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            grant;
    logic            valid_q;
    logic [AW-1:0]   idx_q;
    logic            overrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= rd_en;
            idx_q     <= rd_en ? rd_addr : '0;
            overrun_q <= pixel_start_i && (state_q != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                // A start accepted this cycle reads address 0 and blocks the write.
                if (pixel_start_i && !pause_execute_i) begin
                    rd_en   = 1'b1;
                    pc_d    = AW'(1);
                    state_d = RUN;
                end else if (wr_req_i && !rst_i) begin
                    grant = 1'b1;
                end
            end
            RUN: begin
                rd_en   = 1'b1;
                rd_addr = pc_q;
                pc_d    = pc_q + AW'(1);
                if (pc_q == AW'(NUM_INSTR - 1)) begin
                    pc_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign wr_ack_o      = grant;
    assign mem_we_o      = grant;
    assign mem_wdata_o   = grant ? wr_data_i : '0;
    assign mem_addr_o    = grant ? wr_addr_i : (rd_en ? rd_addr : '0);
    assign instr_valid_o = valid_q;
    assign instr_idx_o   = idx_q;
    assign instr_o       = valid_q ? mem_rdata_i : '0;
    assign exec_done_o   = (state_q == DRAIN);
    assign overrun_o     = overrun_q;
    assign state_o       = state_q;

`ifdef TINY_SHADER_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;

    // Frame clear takes priority over a same-cycle overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i || next_frame_i) begin
            ovr_cnt_q <= 8'd0;
        end else if (overrun_q && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`else
    logic unused_next_frame;

    assign unused_next_frame = next_frame_i;
    assign overrun_cnt_o     = 8'd0;
`endif

endmodule

// File: tb/tb_tiny_shader_sequencer.sv
// Self-checking bench for tiny_shader_sequencer: behavioural RAM, reference model and instruction scoreboard.
module tb_tiny_shader_sequencer;

    localparam int N  = 16;
    localparam int IW = 8;
    localparam int AW = 4;
    localparam int W  = AW + IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pause = 1'b0;
    logic          start = 1'b0;
    logic          next_frame = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [IW-1:0] wr_data = '0;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_idx;
    logic          instr_valid;
    logic          exec_done;
    logic          overrun;
    logic [7:0]    ovr_cnt;
    logic [1:0]    state;

    tiny_shader_sequencer #(.NUM_INSTR(N), .INSTR_W(IW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pause_execute_i(pause),
        .pixel_start_i  (start),
        .next_frame_i   (next_frame),
        .wr_req_i       (wr_req),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_ack_o       (wr_ack),
        .mem_addr_o     (mem_addr),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .instr_o        (instr),
        .instr_idx_o    (instr_idx),
        .instr_valid_o  (instr_valid),
        .exec_done_o    (exec_done),
        .overrun_o      (overrun),
        .overrun_cnt_o  (ovr_cnt),
        .state_o        (state)
    );

    // ---------------- clock / reset / RAM ----------------
    always #5 clk = ~clk;

    logic [IW-1:0] ram [0:N-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) ram[i] <= IW'(16 + i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- reference model ----------------
    logic [W-1:0]  exp_q[$];
    logic [IW-1:0] ref_ram [0:N-1];
    int cyc = 0;
    int m_left = 0;
    int m_cnt = 0;
    int exp_done = 0;
    int exp_ovr = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_left <= 0;
            m_cnt  <= 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) ref_ram[i] <= IW'(16 + i);
        end else begin
            if (next_frame) m_cnt <= 0;
            else if (m_left != 0 && start && m_cnt != 255) m_cnt <= m_cnt + 1;
            if (m_left != 0) begin
                if (start) exp_ovr <= exp_ovr + 1;
                if (m_left == 1) exp_done <= exp_done + 1;
                m_left <= m_left - 1;
            end else if (start && !pause) begin
                for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), ref_ram[i]});
                m_left <= N;
            end else if (wr_req) begin
                ref_ram[wr_addr] <= wr_data;
            end
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int obs_done = 0;
    int obs_ovr = 0;
    int n_valid = 0;
    int last_done_cyc = -1;
    int last_ovr_cyc = -1;
    int last_valid_cyc = -1;
    logic [IW-1:0] seen5 = '0;
    logic [W-1:0]  exp_v;

    // Monitor samples registered outputs mid-period.
    always @(negedge clk) begin
        if (instr_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (instr_idx == AW'(5)) seen5 = instr;
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                exp_v = exp_q.pop_front();
                check("instr", {instr_idx, instr}, exp_v);
            end
        end
        if (exec_done) begin
            obs_done++;
            last_done_cyc = cyc;
        end
        if (overrun) begin
            obs_ovr++;
            last_ovr_cyc = cyc;
        end
        if (mem_we) check("we_when_busy", (m_left == 0) ? 1 : 0, 1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int p);
        p = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic write_req(input logic [AW-1:0] a, input logic [IW-1:0] d, output int ack_cyc);
        ack_cyc = -1;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (wr_ack) begin
                ack_cyc = cyc;
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, a);
                check("wr_data", mem_wdata, d);
                break;
            end
            @(negedge clk);
            #1;
        end
        check("wr_ack_seen", (ack_cyc >= 0) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr, 0);
        check({tag, "_idx"}, instr_idx, 0);
        check({tag, "_done"}, exec_done, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_ack"}, wr_ack, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_cnt"}, ovr_cnt, 0);
        check({tag, "_state"}, state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p, bd, bo, bv, ack;

        repeat (3) tick();
        check_all_zero("rst");
        rst = 1'b0;
        tick();

        // Basic run: valid t+1..t+16, done at t+16.
        bd = obs_done; bv = n_valid;
        pulse_start(p);
        repeat (20) tick();
        check("run_done_cnt", obs_done - bd, 1);
        check("run_done_lat", last_done_cyc - p, 16);
        check("run_valid_cnt", n_valid - bv, 16);
        check("run_last_valid", last_valid_cyc - p, 16);

        // Start during run is dropped with an overrun one cycle later.
        bd = obs_done; bo = obs_ovr;
        pulse_start(p);
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("ovr_cnt_pulses", obs_ovr - bo, 1);
        check("ovr_lat", last_ovr_cyc - p, 6);
        check("ovr_done_cnt", obs_done - bd, 1);

        // Write during run waits for IDLE.
        bd = obs_done;
        pulse_start(p);
        repeat (2) tick();
        write_req(AW'(5), 8'hA5, ack);
        check("wr_run_lat", ack - p, 17);
        check("wr_run_done", obs_done - bd, 1);
        pulse_start(p);
        repeat (20) tick();
        check("wr_idx5", seen5, 8'hA5);

        // Paused: start dropped silently, write acked same cycle.
        bd = obs_done; bo = obs_ovr; bv = n_valid;
        pause = 1'b1;
        start = 1'b1;
        wr_req = 1'b1;
        wr_addr = AW'(9);
        wr_data = 8'h3C;
        #3;
        check("pause_ack", wr_ack, 1);
        check("pause_we", mem_we, 1);
        check("pause_addr", mem_addr, 9);
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
        #1;
        repeat (20) tick();
        check("pause_no_done", obs_done - bd, 0);
        check("pause_no_ovr", obs_ovr - bo, 0);
        check("pause_no_valid", n_valid - bv, 0);
        pause = 1'b0;
        tick();

        // Reset mid-run abandons the program.
        bd = obs_done;
        pulse_start(p);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_cyc", cyc - p, 9);
        check_all_zero("mid_rst");
        rst = 1'b0;
        repeat (20) tick();
        check("mid_rst_no_done", obs_done - bd, 0);
        pulse_start(p);
        repeat (20) tick();
        check("post_rst_done", obs_done - bd, 1);

        // Random writes, runs, and pause raised mid-run.
        for (int k = 0; k < 4; k++) begin
            p = cyc;
            write_req(AW'($urandom_range(0, N - 1)), IW'($urandom_range(0, 255)), ack);
            check("wr_idle_lat", ack - p, 0);
            bd = obs_done;
            pulse_start(p);
            repeat ($urandom_range(2, 10)) tick();
            pause = 1'($urandom_range(0, 1));
            repeat (16) tick();
            pause = 1'b0;
            tick();
            check("rand_done", obs_done - bd, 1);
        end

        // Overrun storm: hold start high for many runs.
        start = 1'b1;
        repeat (340) tick();
        start = 1'b0;
        repeat (20) tick();
`ifdef TINY_SHADER_OVERRUN_CNT_EN
        check("cnt_sat", ovr_cnt, 255);
`else
        check("cnt_off", ovr_cnt, 0);
`endif
        next_frame = 1'b1;
        tick();
        next_frame = 1'b0;
        tick();
        check("cnt_clr", ovr_cnt, 0);

        check("sb_empty", exp_q.size(), 0);
        check("done_total", obs_done, exp_done);
        check("ovr_total", obs_ovr, exp_ovr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
